// File: rtl/reg_file_cmd_ctrl_pkg.sv
// Shared command codes and FSM state encoding for the register-file command controller.
package reg_ctrl_pkg;

   localparam logic [7:0] CMD_WR = 8'hAA;
   localparam logic [7:0] CMD_RD = 8'hBB;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_ADDR = 3'd3,
      RD_WAIT = 3'd4,
      TX_SEND = 3'd5
   } state_t;

endpackage

// File: rtl/reg_file_cmd_ctrl_if.sv
// Signal bundle between the command controller, its byte source/sink and the register file.
interface reg_file_cmd_ctrl_if #(
   parameter int width      = 8,
   parameter int addressBus = 4
);
   logic [width-1:0]      RX_P_Data;
   logic                  RX_D_VLD;
   logic                  WrEN;
   logic                  RdEN;
   logic [addressBus-1:0] Address;
   logic [width-1:0]      WrData;
   logic [width-1:0]      RdData;
   logic                  RdData_Valid;
   logic [width-1:0]      TX_P_Data;
   logic                  TX_D_VLD;
   logic                  TX_Busy;
   logic                  CMD_ERR;

   modport ctrl (
      input  RX_P_Data, RX_D_VLD, RdData, RdData_Valid, TX_Busy,
      output WrEN, RdEN, Address, WrData, TX_P_Data, TX_D_VLD, CMD_ERR
   );

   modport rf (
      input  WrEN, RdEN, Address, WrData,
      output RdData, RdData_Valid
   );
endinterface

// File: rtl/reg_file_cmd_ctrl.sv
// Byte-command front end: 0xAA addr data writes a register, 0xBB addr reads one and
// returns it to the transmitter; unknown commands and read timeouts pulse CMD_ERR.
module reg_file_cmd_ctrl
   import reg_ctrl_pkg::*;
#(
   parameter int width      = 8,
   parameter int addressBus = 4,
   parameter int rdTimeout  = 4
) (
   input  logic                  REF_CLK,
   input  logic                  RST,
   input  logic [width-1:0]      RX_P_Data,
   input  logic                  RX_D_VLD,
   output logic                  WrEN,
   output logic                  RdEN,
   output logic [addressBus-1:0] Address,
   output logic [width-1:0]      WrData,
   input  logic [width-1:0]      RdData,
   input  logic                  RdData_Valid,
   output logic [width-1:0]      TX_P_Data,
   output logic                  TX_D_VLD,
   input  logic                  TX_Busy,
   output logic                  CMD_ERR
);

   localparam int              CNT_W = $clog2(rdTimeout + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(rdTimeout - 1);

   state_t                state_q, state_d;
   logic [addressBus-1:0] addr_q, addr_d;
   logic [width-1:0]      wr_data_q, wr_data_d;
   logic [width-1:0]      tx_hold_q, tx_hold_d;
   logic [width-1:0]      tx_data_q, tx_data_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic                  wr_en_q, wr_en_d;
   logic                  rd_en_q, rd_en_d;
   logic                  tx_vld_q, tx_vld_d;
   logic                  cmd_err_q, cmd_err_d;

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wr_data_d = wr_data_q;
      tx_hold_d = tx_hold_q;
      tx_data_d = tx_data_q;
      cnt_d     = cnt_q;
      wr_en_d   = 1'b0;
      rd_en_d   = 1'b0;
      tx_vld_d  = 1'b0;
      cmd_err_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_Data == width'(CMD_WR)) begin
                  state_d = WR_ADDR;
               end else if (RX_P_Data == width'(CMD_RD)) begin
                  state_d = RD_ADDR;
               end else begin
                  cmd_err_d = 1'b1;
               end
            end
         end
         WR_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_Data[addressBus-1:0];
               state_d = WR_DATA;
            end
         end
         WR_DATA: begin
            if (RX_D_VLD) begin
               wr_en_d   = 1'b1;
               wr_data_d = RX_P_Data;
               state_d   = IDLE;
            end
         end
         RD_ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_Data[addressBus-1:0];
               rd_en_d = 1'b1;
               cnt_d   = '0;
               state_d = RD_WAIT;
            end
         end
         RD_WAIT: begin
            // The RdEN cycle itself is the first of the rdTimeout waiting cycles.
            if (RdData_Valid) begin
               tx_hold_d = RdData;
               cnt_d     = '0;
               state_d   = TX_SEND;
            end else if (cnt_q == CNT_LAST) begin
               cmd_err_d = 1'b1;
               cnt_d     = '0;
               state_d   = IDLE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         TX_SEND: begin
            if (!TX_Busy) begin
               tx_vld_d  = 1'b1;
               tx_data_d = tx_hold_q;
               state_d   = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge REF_CLK) begin
      if (RST) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         wr_data_q <= '0;
         tx_hold_q <= '0;
         tx_data_q <= '0;
         cnt_q     <= '0;
         wr_en_q   <= 1'b0;
         rd_en_q   <= 1'b0;
         tx_vld_q  <= 1'b0;
         cmd_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wr_data_q <= wr_data_d;
         tx_hold_q <= tx_hold_d;
         tx_data_q <= tx_data_d;
         cnt_q     <= cnt_d;
         wr_en_q   <= wr_en_d;
         rd_en_q   <= rd_en_d;
         tx_vld_q  <= tx_vld_d;
         cmd_err_q <= cmd_err_d;
      end
   end

   assign WrEN      = wr_en_q;
   assign RdEN      = rd_en_q;
   assign Address   = addr_q;
   assign WrData    = wr_data_q;
   assign TX_P_Data = tx_data_q;
   assign TX_D_VLD  = tx_vld_q;
   assign CMD_ERR   = cmd_err_q;

endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// Directed bench: drives command bytes on the falling edge, models a 16x8 register
// file with one-cycle read latency, and checks outputs on the falling edge.
module tb_reg_file_cmd_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   reg_file_cmd_ctrl_if #(.width(8), .addressBus(4)) bus ();

   reg_file_cmd_ctrl #(.width(8), .addressBus(4), .rdTimeout(4)) dut (
      .REF_CLK      (clk),
      .RST          (rst),
      .RX_P_Data    (bus.RX_P_Data),
      .RX_D_VLD     (bus.RX_D_VLD),
      .WrEN         (bus.WrEN),
      .RdEN         (bus.RdEN),
      .Address      (bus.Address),
      .WrData       (bus.WrData),
      .RdData       (bus.RdData),
      .RdData_Valid (bus.RdData_Valid),
      .TX_P_Data    (bus.TX_P_Data),
      .TX_D_VLD     (bus.TX_D_VLD),
      .TX_Busy      (bus.TX_Busy),
      .CMD_ERR      (bus.CMD_ERR)
   );

   // Register file model
   logic [7:0] mem [16];
   logic       rdv_en = 1'b1;
   logic [7:0] rf_rdata = 8'h00;
   logic       rf_rvld = 1'b0;
   assign bus.RdData       = rf_rdata;
   assign bus.RdData_Valid = rf_rvld & rdv_en;

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[1] = 8'h5A;
      mem[2] = 8'h81;
      mem[3] = 8'h20;
   end

   always @(posedge clk) begin
      rf_rvld <= 1'b0;
      if (bus.WrEN) mem[bus.Address] <= bus.WrData;
      if (bus.RdEN) begin
         rf_rdata <= mem[bus.Address];
         rf_rvld  <= 1'b1;
      end
   end

   // Pulse counters and WrEN/RdEN overlap monitor
   int n_wr = 0, n_rd = 0, n_tx = 0, n_err = 0, n_both = 0;
   always @(negedge clk) begin
      if (bus.WrEN) n_wr++;
      if (bus.RdEN) n_rd++;
      if (bus.TX_D_VLD) n_tx++;
      if (bus.CMD_ERR) n_err++;
      if (bus.WrEN && bus.RdEN) n_both++;
   end

   int n_cmp = 0;
   int n_mis = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Presents one byte for exactly one cycle; returns at the negedge where the
   // registered reaction to that byte is visible.
   task automatic send_byte(input logic [7:0] b);
      bus.RX_P_Data = b;
      bus.RX_D_VLD  = 1'b1;
      step();
      bus.RX_D_VLD  = 1'b0;
   endtask

   task automatic wait_tx(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         step();
         if (bus.TX_D_VLD) seen = 1'b1;
      end
   endtask

   int  snap_wr, snap_rd, snap_tx, snap_err;
   bit  seen;

   initial begin
      bus.RX_P_Data = 8'h00;
      bus.RX_D_VLD  = 1'b0;
      bus.TX_Busy   = 1'b0;

      // Reset state
      step(); step();
      check("rst_wren",   bus.WrEN, 0);
      check("rst_rden",   bus.RdEN, 0);
      check("rst_addr",   bus.Address, 0);
      check("rst_wrdata", bus.WrData, 0);
      check("rst_txdata", bus.TX_P_Data, 0);
      check("rst_txvld",  bus.TX_D_VLD, 0);
      check("rst_cmderr", bus.CMD_ERR, 0);
      rst = 1'b0;
      step();

      // Write 0x3C to register 5
      snap_wr = n_wr;
      send_byte(8'hAA);
      send_byte(8'h05);
      check("wr_early", bus.WrEN, 0);
      send_byte(8'h3C);
      check("wr_wren",   bus.WrEN, 1);
      check("wr_rden",   bus.RdEN, 0);
      check("wr_addr",   bus.Address, 5);
      check("wr_wrdata", bus.WrData, 8'h3C);
      step();
      check("wr_wren_drop", bus.WrEN, 0);
      check("wr_data_hold", bus.WrData, 8'h3C);
      check("wr_mem5",      mem[5], 8'h3C);
      check("wr_count",     n_wr - snap_wr, 1);

      // Read register 2 -> 0x81
      snap_rd = n_rd; snap_tx = n_tx;
      send_byte(8'hBB);
      send_byte(8'h02);
      check("rd_rden", bus.RdEN, 1);
      check("rd_addr", bus.Address, 2);
      check("rd_wren", bus.WrEN, 0);
      wait_tx(20, seen);
      check("rd_tx_seen", seen, 1);
      check("rd_txdata",  bus.TX_P_Data, 8'h81);
      step();
      check("rd_txvld_drop", bus.TX_D_VLD, 0);
      check("rd_count", n_rd - snap_rd, 1);
      check("rd_txcnt", n_tx - snap_tx, 1);

      // Read register 5 while transmitter is busy; a stray byte meanwhile is dropped
      bus.TX_Busy = 1'b1;
      snap_tx = n_tx; snap_err = n_err;
      send_byte(8'hBB);
      send_byte(8'h05);
      send_byte(8'h7E);
      for (int i = 0; i < 8; i++) step();
      check("busy_no_tx",  n_tx - snap_tx, 0);
      check("busy_no_err", n_err - snap_err, 0);
      bus.TX_Busy = 1'b0;
      step();
      check("busy_txvld",  bus.TX_D_VLD, 1);
      check("busy_txdata", bus.TX_P_Data, 8'h3C);
      step();
      check("busy_txvld_drop", bus.TX_D_VLD, 0);
      check("busy_data_hold",  bus.TX_P_Data, 8'h3C);
      step(); step();
      check("busy_txcnt", n_tx - snap_tx, 1);

      // Unknown command, then read register 3 -> 0x20
      snap_wr = n_wr; snap_rd = n_rd;
      send_byte(8'h7E);
      check("bad_cmderr", bus.CMD_ERR, 1);
      step();
      check("bad_cmderr_drop", bus.CMD_ERR, 0);
      check("bad_no_wr", n_wr - snap_wr, 0);
      check("bad_no_rd", n_rd - snap_rd, 0);
      send_byte(8'hBB);
      send_byte(8'h03);
      wait_tx(20, seen);
      check("bad_next_seen", seen, 1);
      check("bad_next_data", bus.TX_P_Data, 8'h20);
      step();

      // Read timeout: RdData_Valid withheld
      rdv_en = 1'b0;
      snap_tx = n_tx;
      send_byte(8'hBB);
      send_byte(8'h01);
      check("to_rden", bus.RdEN, 1);
      for (int i = 1; i <= 3; i++) begin
         step();
         check("to_no_err_yet", bus.CMD_ERR, 0);
      end
      step();
      check("to_cmderr", bus.CMD_ERR, 1);
      step();
      check("to_cmderr_drop", bus.CMD_ERR, 0);
      check("to_no_tx", n_tx - snap_tx, 0);
      rdv_en = 1'b1;
      // Back in IDLE: a fresh write must be accepted
      send_byte(8'hAA);
      send_byte(8'h17);
      send_byte(8'h11);
      check("to_idle_wren", bus.WrEN, 1);
      check("to_idle_addr", bus.Address, 7);
      step();

      // Reset during WR_DATA aborts the write
      snap_wr = n_wr;
      send_byte(8'hAA);
      send_byte(8'h09);
      bus.RX_P_Data = 8'h55;
      bus.RX_D_VLD  = 1'b1;
      rst = 1'b1;
      step();
      bus.RX_D_VLD = 1'b0;
      rst = 1'b0;
      check("abort_wren",   bus.WrEN, 0);
      check("abort_addr",   bus.Address, 0);
      check("abort_wrdata", bus.WrData, 0);
      check("abort_txdata", bus.TX_P_Data, 0);
      step(); step();
      check("abort_no_wr", n_wr - snap_wr, 0);
      check("abort_mem9",  mem[9], 8'h00);

      check("wr_rd_overlap", n_both, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/reg_file_cmd_ctrl.md
REG_FILE_CMD_CTRL -- requirements
Module: reg_file_cmd_ctrl

Interface
REQ-001 SHALL have parameter: width, 8, data/byte width.
REQ-002 SHALL have parameter: addressBus, 4, register-file address width.
REQ-003 SHALL have parameter: rdTimeout, 4, max cycles waiting for RdData_Valid.
REQ-004 SHALL use one clock and a synchronous, active-high reset: REF_CLK  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-005 SHALL have port: RX_P_Data  in  width  received command/operand byte.
REQ-006 SHALL have port: RX_D_VLD  in  1  one-cycle strobe, RX_P_Data valid.
REQ-007 SHALL have port: WrEN  out  1  register-file write enable.
REQ-008 SHALL have port: RdEN  out  1  register-file read enable.
REQ-009 SHALL have port: Address  out  addressBus  register-file address.
REQ-010 SHALL have port: WrData  out  width  register-file write data.
REQ-011 SHALL have port: RdData  in  width  register-file read data.
REQ-012 SHALL have port: RdData_Valid  in  1  read data valid strobe.
REQ-013 SHALL have port: TX_P_Data  out  width  response byte to transmitter.
REQ-014 SHALL have port: TX_D_VLD  out  1  one-cycle response strobe.
REQ-015 SHALL have port: TX_Busy  in  1  transmitter busy, hold response.
REQ-016 SHALL have port: CMD_ERR  out  1  one-cycle error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, TX_SEND; all outputs registered.
REQ-018 SHALL, in IDLE on RX_D_VLD: 0xAA -> WR_ADDR; 0xBB -> RD_ADDR; any other byte -> CMD_ERR high next cycle, stay IDLE.
REQ-019 SHALL, in WR_ADDR/RD_ADDR on RX_D_VLD, latch RX_P_Data[addressBus-1:0] as address, upper bits ignored.
REQ-020 SHALL, in WR_DATA on RX_D_VLD, drive WrEN=1, WrData=byte, Address=latched for exactly the next cycle, then return to IDLE.
REQ-021 SHALL, after RD_ADDR address capture, drive RdEN=1 for exactly the next cycle and enter RD_WAIT.
REQ-022 SHALL never assert WrEN and RdEN in the same cycle.
REQ-023 SHALL, in RD_WAIT, capture RdData into a TX holding register on RdData_Valid and enter TX_SEND.
REQ-024 SHALL, if RdData_Valid is absent for rdTimeout cycles after RdEN, pulse CMD_ERR and return to IDLE.
REQ-025 SHALL, in TX_SEND, wait while TX_Busy=1; on first cycle with TX_Busy=0, drive TX_D_VLD=1 with TX_P_Data=held byte for one cycle, then return to IDLE.
REQ-026 SHALL ignore (drop) RX_D_VLD bytes received in RD_WAIT and TX_SEND.
REQ-027 SHALL hold Address/WrData/TX_P_Data stable between strobes; WrEN, RdEN, TX_D_VLD, CMD_ERR default 0.
REQ-028 SHALL achieve latency: data byte strobe -> WrEN 1 cycle; address byte strobe -> RdEN 1 cycle.

Reset
REQ-029 SHALL, when RST=1 at a REF_CLK edge, enter IDLE and clear all outputs, latched address, holding register and timeout counter to 0.
REQ-030 SHALL let RST abort any in-progress command (including pending TX); no WrEN/RdEN/TX_D_VLD is issued from the aborted command.

Structure
REQ-031 SHALL take command codes 0xAA/0xBB and the state encoding from a shared package (reg_ctrl_pkg).
REQ-032 SHALL be a single module with no sub-module; the timeout counter is inline, width clog2(rdTimeout+1).

Verification
REQ-033 SHALL test: reset, then bytes 0xAA,0x05,0x3C -> one WrEN pulse, Address=5, WrData=0x3C; reg 5 = 0x3C.
REQ-034 SHALL test: reset, then 0xBB,0x02 with register file attached -> RdEN pulse, then TX_D_VLD with TX_P_Data=0x81.
REQ-035 SHALL test: read with TX_Busy=1 for 10 cycles -> TX_D_VLD asserted only on the first cycle after TX_Busy falls, once.
REQ-036 SHALL test: byte 0x7E in IDLE -> one-cycle CMD_ERR, no WrEN/RdEN; next 0xBB,0x03 returns 0x20.
REQ-037 SHALL test: 0xBB,0x01 with RdData_Valid tied 0 -> CMD_ERR after 4 cycles, FSM IDLE; RST mid-WR_DATA -> no WrEN, outputs 0.
